// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter slice.
package cdb_arbiter_pkg;

  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_RB_SIZE    = 8;
  localparam int DEF_RB_INDEX   = 3;
  localparam int DEF_FU_NUM     = 4;
  localparam int DEF_STORER_NUM = 1;
  localparam int DEF_CDB_PORTS  = 2;
  localparam int DEF_FIFO_DEPTH = 2;

  // Next functional-unit slot after fu, wrapping at fu_num (works for any fu_num).
  function automatic int wrap_next(input int fu, input int fu_num);
    return (fu + 1 >= fu_num) ? 0 : fu + 1;
  endfunction

  // Pointer width that never collapses to zero bits for tiny depths.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-functional-unit result FIFO: single clock, push/pop with flush, exposes count and empty.
module cdb_fu_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_WORD_SIZE + DEF_RB_INDEX,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Power-of-two depths wrap on their own; a single-entry FIFO keeps its pointer at 0.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (DEPTH == 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // A full FIFO refuses a push even when the head pops in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; writes are suppressed while reset or flush empties the queue.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs, round-robin grant of up to CDB_PORTS
// heads per cycle, and registered one-hot-per-ROB-entry broadcast of data/valid/address.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int RB_SIZE    = DEF_RB_SIZE,
  parameter int RB_INDEX   = DEF_RB_INDEX,
  parameter int FU_NUM     = DEF_FU_NUM,
  parameter int STORER_NUM = DEF_STORER_NUM,
  parameter int CDB_PORTS  = DEF_CDB_PORTS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [FU_NUM-1:0]             fu_valid,
  output logic [FU_NUM-1:0]             fu_ready,
  input  logic [FU_NUM*WORD_SIZE-1:0]   fu_data,
  input  logic [FU_NUM*RB_INDEX-1:0]    fu_index,
  input  logic [STORER_NUM*WORD_SIZE-1:0] fu_addr,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_addr,
  output logic                          index_conflict
);

  localparam int PAY_W      = 2 * WORD_SIZE + RB_INDEX;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int FU_W       = ptr_width(FU_NUM);
  localparam int STORE_BASE = FU_NUM - STORER_NUM;

  // Payload layout inside each FIFO entry: {addr, index, data}.
  localparam int DATA_LSB = 0;
  localparam int IDX_LSB  = WORD_SIZE;
  localparam int ADDR_LSB = WORD_SIZE + RB_INDEX;

  logic [PAY_W-1:0]            push_payload [FU_NUM];
  logic [PAY_W-1:0]            head_payload [FU_NUM];
  logic [CNT_W-1:0]            fifo_count   [FU_NUM];
  logic [FU_NUM-1:0]           fifo_empty;
  logic [FU_NUM-1:0]           fifo_pop;

  logic [FU_W-1:0]             rr_ptr;
  logic [FU_W-1:0]             rr_next;
  logic [RB_SIZE-1:0]          valid_next;
  logic [WORD_SIZE*RB_SIZE-1:0] data_next;
  logic [RB_SIZE*WORD_SIZE-1:0] addr_next;
  logic                        conflict_next;

  for (genvar i = 0; i < FU_NUM; i++) begin : g_fu
    logic [WORD_SIZE-1:0] store_addr;

    // Only the top STORER_NUM slots carry a store address; everyone else queues zero.
    if (i >= STORE_BASE) begin : g_store
      assign store_addr = fu_addr[(i - STORE_BASE)*WORD_SIZE +: WORD_SIZE];
    end else begin : g_alu
      assign store_addr = '0;
    end

    assign push_payload[i] = {store_addr,
                              fu_index[i*RB_INDEX +: RB_INDEX],
                              fu_data[i*WORD_SIZE +: WORD_SIZE]};

    // Ready is purely a function of occupancy so producers never see a combinational path from grants.
    assign fu_ready[i] = (fifo_count[i] < CNT_W'(FIFO_DEPTH));

    cdb_fu_fifo #(
      .WIDTH (PAY_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push    (fu_valid[i]),
      .pop     (fifo_pop[i]),
      .wr_data (push_payload[i]),
      .rd_data (head_payload[i]),
      .count   (fifo_count[i]),
      .empty   (fifo_empty[i])
    );
  end

  // Round-robin scan from rr_ptr: grant the first CDB_PORTS non-empty heads in scan order,
  // place each into its ROB slot, and let the earlier lane keep a contested slot.
  always_comb begin
    int scan;
    int lanes;
    int last_fu;
    logic any_grant;
    logic [RB_INDEX-1:0]  head_idx;
    logic [WORD_SIZE-1:0] head_data;
    logic [WORD_SIZE-1:0] head_addr;

    fifo_pop      = '0;
    valid_next    = '0;
    data_next     = '0;
    addr_next     = '0;
    conflict_next = 1'b0;
    rr_next       = rr_ptr;
    scan          = int'(rr_ptr);
    lanes         = 0;
    last_fu       = 0;
    any_grant     = 1'b0;
    head_idx      = '0;
    head_data     = '0;
    head_addr     = '0;

    for (int k = 0; k < FU_NUM; k++) begin
      if (!fifo_empty[scan] && lanes < CDB_PORTS) begin
        fifo_pop[scan] = 1'b1;
        lanes          = lanes + 1;
        last_fu        = scan;
        any_grant      = 1'b1;
        head_data      = head_payload[scan][DATA_LSB +: WORD_SIZE];
        head_idx       = head_payload[scan][IDX_LSB +: RB_INDEX];
        head_addr      = head_payload[scan][ADDR_LSB +: WORD_SIZE];
        // Indices beyond the ROB match no slot and vanish without a conflict.
        for (int s = 0; s < RB_SIZE; s++) begin
          if (int'(head_idx) == s) begin
            if (valid_next[s]) begin
              conflict_next = 1'b1;
            end else begin
              valid_next[s]                        = 1'b1;
              data_next[s*WORD_SIZE +: WORD_SIZE]  = head_data;
              addr_next[s*WORD_SIZE +: WORD_SIZE]  = head_addr;
            end
          end
        end
      end
      scan = wrap_next(scan, FU_NUM);
    end

    if (any_grant) begin
      rr_next = FU_W'(wrap_next(last_fu, FU_NUM));
    end
  end

  // Broadcast registers and the round-robin pointer; reset wins over flush, both clear everything.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rr_ptr         <= '0;
      CDB_data_valid <= '0;
      CDB_data_data  <= '0;
      CDB_data_addr  <= '0;
      index_conflict <= 1'b0;
    end else begin
      rr_ptr         <= rr_next;
      CDB_data_valid <= valid_next;
      CDB_data_data  <= data_next;
      CDB_data_addr  <= addr_next;
      index_conflict <= conflict_next;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all checked
// cycle by cycle against a queue-level model of the FIFOs and round-robin grant rules.
module tb_cdb_arbiter;

  localparam int W  = 32;
  localparam int RB = 8;
  localparam int RI = 3;
  localparam int FN = 4;
  localparam int SN = 1;
  localparam int P  = 2;
  localparam int D  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [FN-1:0]     fu_valid;
  logic [FN-1:0]     fu_ready;
  logic [FN*W-1:0]   fu_data;
  logic [FN*RI-1:0]  fu_index;
  logic [SN*W-1:0]   fu_addr;
  logic [W*RB-1:0]   CDB_data_data;
  logic [RB-1:0]     CDB_data_valid;
  logic [RB*W-1:0]   CDB_data_addr;
  logic              index_conflict;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    logic [W-1:0] addr;
  } item_t;

  item_t mq   [FN][D];
  int    mcnt [FN];
  int    mrr;

  bit count_fu2;
  int fu2_acc;
  int fu2_seen;
  bit saw_fu3;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .fu_valid       (fu_valid),
    .fu_ready       (fu_ready),
    .fu_data        (fu_data),
    .fu_index       (fu_index),
    .fu_addr        (fu_addr),
    .CDB_data_data  (CDB_data_data),
    .CDB_data_valid (CDB_data_valid),
    .CDB_data_addr  (CDB_data_addr),
    .index_conflict (index_conflict)
  );

  task automatic check_output(input string tag, input logic [RB*W-1:0] obs, input logic [RB*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int f, input logic [W-1:0] d, input int idx, input logic [W-1:0] a);
    fu_valid[f] = 1'b1;
    fu_data[f*W +: W] = d;
    fu_index[f*RI +: RI] = RI'(idx);
    if (f >= FN - SN) fu_addr[(f-(FN-SN))*W +: W] = a;
  endtask

  task automatic model_clear();
    for (int f = 0; f < FN; f++) mcnt[f] = 0;
    mrr = 0;
  endtask

  // One clock: predict grants from the model queues, advance the model, then compare after the edge.
  task automatic step(input string tag);
    logic [RB-1:0]   ev;
    logic [RB*W-1:0] ed;
    logic [RB*W-1:0] ea;
    logic            ec;
    logic [FN-1:0]   mready;
    bit              popf [FN];
    bit              acc  [FN];
    int              ng;
    int              last;
    int              f;
    item_t           it;

    ev = '0; ed = '0; ea = '0; ec = 1'b0; ng = 0; last = -1;
    for (int i = 0; i < FN; i++) begin
      mready[i] = (mcnt[i] < D);
      popf[i]   = 1'b0;
      acc[i]    = fu_valid[i] && mready[i];
    end
    if (!reset) check_output({tag, "/ready"}, fu_ready, mready);

    for (int k = 0; k < FN; k++) begin
      f = (mrr + k) % FN;
      if (mcnt[f] > 0 && ng < P) begin
        popf[f] = 1'b1;
        ng++;
        last = f;
        it = mq[f][0];
        if (it.idx < RB) begin
          if (ev[it.idx]) ec = 1'b1;
          else begin
            ev[it.idx] = 1'b1;
            ed[it.idx*W +: W] = it.data;
            ea[it.idx*W +: W] = it.addr;
          end
        end
      end
    end

    if (reset || flush) begin
      model_clear();
      ev = '0; ed = '0; ea = '0; ec = 1'b0;
    end else begin
      for (int i = 0; i < FN; i++) begin
        if (popf[i]) begin
          for (int j = 0; j < D - 1; j++) mq[i][j] = mq[i][j+1];
          mcnt[i]--;
        end
      end
      for (int i = 0; i < FN; i++) begin
        if (acc[i]) begin
          it.data = fu_data[i*W +: W];
          it.idx  = int'(fu_index[i*RI +: RI]);
          it.addr = (i >= FN - SN) ? fu_addr[(i-(FN-SN))*W +: W] : '0;
          mq[i][mcnt[i]] = it;
          mcnt[i]++;
          if (i == 2 && count_fu2) fu2_acc++;
        end
      end
      if (last >= 0) mrr = (last + 1) % FN;
    end

    @(posedge clk);
    #1;
    check_output({tag, "/valid"}, CDB_data_valid, ev);
    check_output({tag, "/data"}, CDB_data_data, ed);
    check_output({tag, "/addr"}, CDB_data_addr, ea);
    check_output({tag, "/conflict"}, index_conflict, ec);
    if (count_fu2 && CDB_data_valid[2]) fu2_seen++;
    if (CDB_data_valid[7] && CDB_data_data[7*W +: W] == 32'h3333) saw_fu3 = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    fu_valid = '0; fu_data = '0; fu_index = '0; fu_addr = '0;
    count_fu2 = 1'b0; fu2_acc = 0; fu2_seen = 0; saw_fu3 = 1'b0;
    model_clear();
    $display("[TB] reset and idle");
    step("reset0");
    step("reset1");
    reset = 1'b0;
    check_output("reset/ready_ones", fu_ready, 4'b1111);
    check_output("reset/valid_zero", CDB_data_valid, '0);
    for (int n = 0; n < 10; n++) step("idle");

    $display("[TB] single result");
    apply_stimulus(1, 32'hDEAD, 5, '0);
    step("single_push");
    fu_valid = '0;
    step("single_bcast");
    check_output("single/valid_const", CDB_data_valid, 8'b0010_0000);
    check_output("single/slot5", CDB_data_data[5*W +: W], 32'hDEAD);
    step("single_after");
    check_output("single/pulse_gone", CDB_data_valid, '0);

    $display("[TB] contention");
    flush = 1'b1; step("flush_pre_cont"); flush = 1'b0;
    for (int i = 0; i < FN; i++) apply_stimulus(i, 32'h10 + i, i, '0);
    step("cont_push");
    fu_valid = '0;
    step("cont_first");
    check_output("cont/first_pair", CDB_data_valid, 8'b0000_0011);
    step("cont_second");
    check_output("cont/second_pair", CDB_data_valid, 8'b0000_1100);

    $display("[TB] starvation");
    for (int n = 0; n < 20; n++) begin
      fu_valid = '0;
      apply_stimulus(0, 32'h100 + n, 0, '0);
      apply_stimulus(1, 32'h200 + n, 1, '0);
      if (n == 0) apply_stimulus(3, 32'h3333, 7, 32'h44);
      step("starve");
    end
    fu_valid = '0;
    for (int n = 0; n < 4; n++) step("starve_drain");
    check_output("starve/fu3_served", saw_fu3, 1'b1);

    $display("[TB] backpressure");
    flush = 1'b1; step("flush_pre_bp"); flush = 1'b0;
    count_fu2 = 1'b1;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < FN; i++) apply_stimulus(i, (i << 16) | n, i, 32'h900 + n);
      step("bp");
      if (n == 1) check_output("bp/fu2_full", fu_ready[2], 1'b0);
    end
    fu_valid = '0;
    for (int n = 0; n < 8; n++) step("bp_drain");
    count_fu2 = 1'b0;
    check_output("bp/fu2_no_loss_dup", fu2_seen, fu2_acc);

    $display("[TB] store path");
    flush = 1'b1; step("flush_pre_store"); flush = 1'b0;
    apply_stimulus(3, 32'h7, 6, 32'h1000);
    apply_stimulus(0, 32'h55, 1, '0);
    step("store_push");
    fu_valid = '0;
    step("store_bcast");
    check_output("store/valid", CDB_data_valid, 8'b0100_0010);
    check_output("store/slot6_data", CDB_data_data[6*W +: W], 32'h7);
    check_output("store/slot6_addr", CDB_data_addr[6*W +: W], 32'h1000);
    check_output("store/slot1_addr", CDB_data_addr[1*W +: W], '0);

    $display("[TB] flush with queued results");
    for (int i = 0; i < 3; i++) apply_stimulus(i, 32'h600 + i, i, '0);
    step("flush_fill");
    fu_valid = '0;
    flush = 1'b1; step("flush_edge"); flush = 1'b0;
    check_output("flush/cleared", CDB_data_valid, '0);
    for (int n = 0; n < 3; n++) begin
      step("flush_after");
      check_output("flush/quiet", CDB_data_valid, '0);
    end

    $display("[TB] index conflict");
    apply_stimulus(0, 32'hA, 4, '0);
    apply_stimulus(1, 32'hB, 4, '0);
    step("conf_push");
    fu_valid = '0;
    step("conf_bcast");
    check_output("conf/valid", CDB_data_valid, 8'b0001_0000);
    check_output("conf/slot4", CDB_data_data[4*W +: W], 32'hA);
    check_output("conf/pulse", index_conflict, 1'b1);
    step("conf_after");
    check_output("conf/pulse_gone", index_conflict, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      fu_valid = FN'($urandom);
      for (int i = 0; i < FN; i++) begin
        fu_data[i*W +: W] = $urandom;
        fu_index[i*RI +: RI] = RI'($urandom_range(RB - 1));
      end
      fu_addr = $urandom;
      flush = ($urandom_range(31) == 0);
      reset = ($urandom_range(99) == 0);
      step("rand");
    end
    reset = 1'b0; flush = 1'b0; fu_valid = '0;
    for (int n = 0; n < 4; n++) step("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
